data_memory_pipe: RTL and testbench

// - Parametrised, pipelined data memory; replaces the single-cycle word-only data memory on the MIPS datapath.
// - Byte-addressed, big-endian; supports byte/half/word loads and stores with optional sign-extension (lb/lbu/lh/lhu/sb/sh).
// - Fixed read latency set by parameter; valid/ready request side, valid/ready response side with backpressure.
// - Out-of-range and misaligned accesses are flagged, never executed.

---
 rtl/data_memory_pipe.sv | 169 ++++++++++++++++
 tb/tb_data_memory_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipe.sv
// ============================================================================
// data_memory_pipe : pipelined byte-addressed big-endian data memory with
// byte/half/word access, fixed read latency and valid/ready handshakes.
// Optional feature macro: DMEM_STATS_EN (access statistics counters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              stall;
  logic              accept;
  logic              req_err;
  logic              out_of_range;
  logic              misaligned;
  logic              do_write;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        boff;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_mask;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  logic              st_vld  [RD_LATENCY];
  logic              st_err  [RD_LATENCY];
  logic [DATA_W-1:0] st_data [RD_LATENCY];

  assign rsp_valid = st_vld[RD_LATENCY-1];
  assign rsp_err   = st_err[RD_LATENCY-1];
  assign rsp_rdata = st_data[RD_LATENCY-1];
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;

  assign idx     = req_addr[IDX_W+1:2];
  assign boff    = req_addr[1:0];
  assign rd_word = mem[idx];

  // Any address bit at or above the array size means the byte lies past the end.
  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;

  always_comb begin
    misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    req_err    = (req_size == SZ_ILL) || misaligned || out_of_range;
  end

  // Big-endian lane selection: the lowest byte address is the most significant lane.
  always_comb begin
    ld_byte = 8'h00;
    case (boff)
      2'd0:    ld_byte = rd_word[31:24];
      2'd1:    ld_byte = rd_word[23:16];
      2'd2:    ld_byte = rd_word[15:8];
      default: ld_byte = rd_word[7:0];
    endcase
    ld_half = req_addr[1] ? rd_word[15:0] : rd_word[31:16];

    case (req_size)
      SZ_BYTE: ld_data = {{(DATA_W-8){req_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{(DATA_W-16){req_signed & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (req_size)
      SZ_BYTE: begin
        wr_mask = 4'b1000 >> boff;
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_mask = req_addr[1] ? 4'b0011 : 4'b1100;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_data = req_wdata;
      end
    endcase
  end

  assign do_write = accept && req_we && !req_err && rst_n;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Stores and errored requests carry zero data so the response side needs no muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        st_vld[s]  <= 1'b0;
        st_err[s]  <= 1'b0;
        st_data[s] <= '0;
      end
    end else if (!stall) begin
      st_vld[0]  <= accept;
      st_err[0]  <= accept && req_err;
      st_data[0] <= (accept && !req_we && !req_err) ? ld_data : '0;
      for (int s = 1; s < RD_LATENCY; s++) begin
        st_vld[s]  <= st_vld[s-1];
        st_err[s]  <= st_err[s-1];
        st_data[s] <= st_data[s-1];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else if (accept) begin
      if (req_err) begin
        if (stat_err != '1) stat_err <= stat_err + 32'd1;
      end else if (req_we) begin
        if (stat_wr != '1) stat_wr <= stat_wr + 32'd1;
      end else begin
        if (stat_rd != '1) stat_rd <= stat_rd + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench for data_memory_pipe: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a byte-array model.
`default_nettype none

module tb_data_memory_pipe;

  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_err;
  int          m_rd = 0, m_wr = 0, m_err = 0;
`endif

  data_memory_pipe #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t       exp_q[$];
  rsp_t       mon_e;
  logic [7:0] mb [DEPTH*4];
  int         checks = 0;
  int         errors = 0;
  int         n_rsp  = 0;
  vec_t       tbl [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: memory as a flat byte array, lowest address = most significant byte.
  function automatic rsp_t model(input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic sgn,
                                 input logic [31:0] wdata);
    rsp_t        r;
    logic [31:0] v;
    int          nb;
    r.rdata = '0;
    r.err   = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(DEPTH*4));
    if (!r.err) begin
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      if (we) begin
        for (int i = 0; i < nb; i++) mb[addr + 32'(i)] = 8'(wdata >> (8*(nb-1-i)));
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mb[addr + 32'(i)]);
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        r.rdata = v;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
`ifdef DMEM_STATS_EN
      m_rd = 0; m_wr = 0; m_err = 0;
`endif
    end else begin
      chk("req_ready_rule", 32'(req_ready), 32'(!(rsp_valid && !rsp_ready)));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got response %h err %b, expected none", rsp_rdata, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          n_rsp++;
        end
      end
      if (req_valid && req_ready) begin
        mon_e = model(req_we, req_addr, req_size, req_signed, req_wdata);
        exp_q.push_back(mon_e);
`ifdef DMEM_STATS_EN
        if (mon_e.err) m_err++;
        else if (req_we) m_wr++;
        else m_rd++;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply(input vec_t v, input int k);
    int lat;
    rsp_ready = 1'b1;
    set_req(v.we, v.addr, v.size, v.sgn, v.wdata);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(RD_LAT));
    chk($sformatf("vec%0d_rdata", k), rsp_rdata, v.exp_rdata);
    chk($sformatf("vec%0d_err", k), 32'(rsp_err), 32'(v.exp_err));
    tick();
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] wdata,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] a;
    logic [1:0]  sz;
    int r;

    tbl[0]  = mk(1, 32'h10,  2, 0, 32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(0, 32'h10,  2, 0, 32'h0,        32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 32'h10,  0, 1, 32'h0,        32'hFFFFFFDE, 0);
    tbl[3]  = mk(0, 32'h13,  0, 0, 32'h0,        32'h000000EF, 0);
    tbl[4]  = mk(0, 32'h12,  1, 1, 32'h0,        32'hFFFFBEEF, 0);
    tbl[5]  = mk(0, 32'h10,  1, 0, 32'h0,        32'h0000DEAD, 0);
    tbl[6]  = mk(0, 32'h11,  0, 0, 32'h0,        32'h000000AD, 0);
    tbl[7]  = mk(0, 32'h12,  0, 1, 32'h0,        32'hFFFFFFBE, 0);
    tbl[8]  = mk(1, 32'h12,  1, 0, 32'h00001234, 32'h0,        0);
    tbl[9]  = mk(0, 32'h10,  2, 0, 32'h0,        32'hDEAD1234, 0);
    tbl[10] = mk(0, 32'h12,  1, 1, 32'h0,        32'h00001234, 0);
    tbl[11] = mk(0, 32'h11,  2, 0, 32'h0,        32'h0,        1);
    tbl[12] = mk(1, 32'h400, 2, 0, 32'hCAFEF00D, 32'h0,        1);
    tbl[13] = mk(0, 32'h0,   2, 0, 32'h0,        32'h0,        0);
    tbl[14] = mk(0, 32'h3FC, 2, 0, 32'h0,        32'h0,        0);
    tbl[15] = mk(0, 32'h20,  3, 0, 32'h0,        32'h0,        1);
    tbl[16] = mk(1, 32'h20,  3, 0, 32'hFFFFFFFF, 32'h0,        1);
    tbl[17] = mk(0, 32'h20,  2, 0, 32'h0,        32'h0,        0);
    tbl[18] = mk(0, 32'h13,  1, 0, 32'h0,        32'h0,        1);
    tbl[19] = mk(1, 32'h21,  1, 0, 32'h0000BEEF, 32'h0,        1);
    tbl[20] = mk(1, 32'h01,  0, 1, 32'hFFFFFFA5, 32'h0,        0);
    tbl[21] = mk(0, 32'h00,  2, 0, 32'h0,        32'h00A50000, 0);
    tbl[22] = mk(1, 32'h03,  0, 0, 32'h00000077, 32'h0,        0);
    tbl[23] = mk(0, 32'h00,  2, 0, 32'h0,        32'h00A50077, 0);
    tbl[24] = mk(0, 32'h3FF, 0, 1, 32'h0,        32'h0,        0);
    tbl[25] = mk(0, 32'hFFFFFFFC, 2, 0, 32'h0,   32'h0,        1);
    tbl[26] = mk(1, 32'h3FE, 1, 0, 32'h00008001, 32'h0,        0);
    tbl[27] = mk(0, 32'h3FE, 1, 1, 32'h0,        32'hFFFF8001, 0);
    tbl[28] = mk(0, 32'h3FE, 1, 0, 32'h0,        32'h00008001, 0);

    // Reset state
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_STATS_EN
    chk("reset_stat_rd", stat_rd, 32'd0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) begin
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Known memory contents for the model
    for (int w = 0; w < DEPTH; w++) begin
      set_req(1'b1, 32'(w*4), 2'b10, 1'b0, 32'h0);
      tick();
    end
    drain();

    for (int k = 0; k < 29; k++) apply(tbl[k], k);
    drain();

    // Backpressure: three loads, consumer stalled for four cycles
    rsp_ready = 1'b0;
    set_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    chk("bp_ready_a", 32'(req_ready), 32'd1);
    tick();
    set_req(1'b0, 32'h3FE, 2'b01, 1'b0, 32'h0);
    chk("bp_ready_b", 32'(req_ready), 32'd1);
    tick();
    set_req(1'b0, 32'h03, 2'b00, 1'b0, 32'h0);
    repeat (4) begin
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      chk("bp_rsp_hold", rsp_rdata, 32'hDEAD1234);
      tick();
    end
    base = n_rsp;
    rsp_ready = 1'b1;
    tick();
    drain();
    chk("bp_rsp_count", 32'(n_rsp - base), 32'd3);

    // Reset with two loads in flight
    rsp_ready = 1'b0;
    set_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    tick();
    set_req(1'b0, 32'h00, 2'b10, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
`ifdef DMEM_STATS_EN
    chk("midrst_stat_rd", stat_rd, 32'd0);
    chk("midrst_stat_err", stat_err, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) begin
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 15);
      sz = (r <= 4) ? 2'd0 : (r <= 9) ? 2'd1 : (r <= 14) ? 2'd2 : 2'd3;
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15) * 4)
                                       : 32'($urandom_range(0, DEPTH-1) * 4);
      if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
      else if (sz == 2'd1) a = a + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 4095));
      set_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

`ifdef DMEM_STATS_EN
    chk("stat_rd", stat_rd, 32'(m_rd));
    chk("stat_wr", stat_wr, 32'(m_wr));
    chk("stat_err", stat_err, 32'(m_err));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
